bcd_operand_entry: RTL
======================

// Module: bcd_operand_entry
// PURPOSE
//  Keypad-side entry stage of the 2-digit BCD calculator datapath.
//  Collects decoded key presses into operands A (A2 A1) and B (B2 B1).
//  Directly drives the A2/A1/B2/B1 inputs of the combinational BCD subtractor.
//  Sequences the A-entry, B-entry and result phases.
// PARAMETERS
//  TIMEOUT_CYCLES  40_000_000  idle cycles before auto-clear (used only with ENTRY_TIMEOUT_EN)
//  TMR_W           26          timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1  system clock, single domain
//  rst          in   1  asynchronous, active-high reset
//  key_valid    in   1  one-cycle strobe: key_code valid this cycle (already debounced)
//  key_code     in   4  0-9 digit, 11 minus, 14 clear, 15 equals; 10/12/13 ignored
//  A2,A1        out  4  operand A tens/units, BCD
//  B2,B1        out  4  operand B tens/units, BCD
//  phase        out  2  0 = ENTER_A, 1 = ENTER_B, 2 = RESULT (3 unused)
//  result_valid out  1  high while phase == RESULT; display selects subtractor output
//  op_start     out  1  one-cycle pulse on entry to RESULT
// BEHAVIOUR
//  - Reset: A2=A1=B2=B1=0, phase=ENTER_A, result_valid=0, op_start=0, timer=0.
//  - All outputs registered; a key sampled at edge N is reflected after edge N.
//  - Keys are acted on only when key_valid=1; key_code is don't-care otherwise.
//  - Digit d in ENTER_A: A2<=A1, A1<=d (shift-left entry).
//    Third and later digits discard the old tens digit, e.g. 1,2,3 -> A=23.
//  - Digit in ENTER_B: same shift into B2/B1.
//  - Minus (11) in ENTER_A: phase<=ENTER_B, B2=B1=0. Minus in ENTER_B or RESULT is ignored.
//  - Equals (15) in ENTER_B: phase<=RESULT, op_start=1 for exactly one cycle.
//    Equals in ENTER_A or RESULT is ignored; no op_start.
//  - Clear (14) in any phase: all operands 0, phase<=ENTER_A. Highest priority.
//  - Digit d in RESULT: start a new calculation.
//    A2=0, A1=d, B2=B1=0, phase<=ENTER_A, result_valid falls.
//  - Operands hold during RESULT so the subtractor output stays stable.
//  - Codes 10/12/13: no state change in any phase.
//  - Non-BCD values are never written to any operand register.
//  - Reset mid-entry: immediate return to reset values, async to clk.
//  - key_valid held high for several cycles: each cycle counts as a key.
//    Upstream guarantees single-cycle pulses.
// CONFIGURATION
//  ENTRY_TIMEOUT_EN defined:
//    - Idle counter increments each cycle; it clears on any key_valid.
//    - Counter reaching TIMEOUT_CYCLES-1 with no key performs the clear action.
//      Counter saturates until the next key.
//    - Timeout expiry and key_valid in the same cycle: the key wins, no clear.
//  ENTRY_TIMEOUT_EN undefined:
//    - No counter logic is built; state is held indefinitely.
//    - TIMEOUT_CYCLES and TMR_W are unused.
// STRUCTURE
//  - Shared package calc_pkg holds:
//    - key code constants KEY_MINUS=11, KEY_CLR=14, KEY_EQ=15;
//    - phase encodings PH_A/PH_B/PH_RES;
//    - BCD digit width 4.
//    The subtractor and display stages include the same package.
//  - One sub-module, bcd_digit_reg: 2-digit shift register with load, clear and shift.
//    Instantiated twice (A and B).
//  - The FSM and the optional timer stay in this module.
// TESTING
//  - Reset, then keys 4,2,minus,1,7,equals.
//    A2A1=42, B2B1=17, phase 0->1->2, op_start high for exactly 1 cycle.
//  - Keys 1,2,3 in ENTER_A -> A2A1=23.
//    Then minus,9 -> B2B1=09.
//  - Equals in ENTER_A, minus in ENTER_B, equals in RESULT.
//    No phase change, no op_start, operands unchanged.
//  - In RESULT with A=42 B=17, key 5 -> A2A1=05, B=00, phase=0, result_valid=0.
//  - Clear in ENTER_B with A=88, B=3 -> all operands 0, phase=0.
//    Assert rst mid-entry -> outputs 0 before the next clk edge.
//  - With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter 7, idle 16 cycles -> A=00, phase=0.
//    Key arriving at cycle 15 -> no clear.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the BCD calculator stages
// (operand entry, subtractor, display).
//   BCD_W       width of one BCD digit
//   KEY_*       keypad codes with a control meaning (0-9 are digits)
//   phase_t     calculator phase encoding, also driven onto o_phase
//   is_digit()  true for codes that are valid BCD digits
package calc_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] KEY_MINUS = 4'd11;
  localparam logic [BCD_W-1:0] KEY_CLR   = 4'd14;
  localparam logic [BCD_W-1:0] KEY_EQ    = 4'd15;

  typedef enum logic [1:0] {
    PH_A   = 2'd0,
    PH_B   = 2'd1,
    PH_RES = 2'd2
  } phase_t;

  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_reg.sv
// bcd_digit_reg: two-digit BCD operand register with shift-left entry.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clr          clear both digits (highest priority)
//   i_load         tens <= 0, units <= i_digit (first digit of a fresh operand)
//   i_shift        tens <= units, units <= i_digit
//   i_digit        incoming BCD digit; the caller only asserts load/shift for 0-9
//   o_tens/o_units registered digits
module bcd_digit_reg
  import calc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_units
);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_units;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_clr) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (i_load) begin
      r_tens  <= '0;
      r_units <= i_digit;
    end else if (i_shift) begin
      r_tens  <= r_units;
      r_units <= i_digit;
    end
  end

  assign o_tens  = r_tens;
  assign o_units = r_units;

endmodule

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: keypad entry stage of the 2-digit BCD calculator.
// Builds operands A (o_a2 o_a1) and B (o_b2 o_b1) from key presses and
// sequences ENTER_A -> ENTER_B -> RESULT.
// Optional feature macro: ENTRY_TIMEOUT_EN (idle auto-clear after
// TIMEOUT_CYCLES cycles without a key; TMR_W must hold TIMEOUT_CYCLES).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_key_valid         one-cycle strobe qualifying i_key_code
//   i_key_code          0-9 digit, 11 minus, 14 clear, 15 equals, others ignored
//   o_a2/o_a1/o_b2/o_b1 operand digits to the subtractor
//   o_phase             0 ENTER_A, 1 ENTER_B, 2 RESULT
//   o_result_valid      high while in RESULT
//   o_op_start          one-cycle pulse on entry to RESULT
//
// state  | meaning
// PH_A   | collecting operand A digits
// PH_B   | collecting operand B digits
// PH_RES | operands frozen, subtractor result shown
module bcd_operand_entry
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40_000_000,
  parameter int TMR_W          = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_key_valid,
  input  logic [BCD_W-1:0] i_key_code,
  output logic [BCD_W-1:0] o_a2,
  output logic [BCD_W-1:0] o_a1,
  output logic [BCD_W-1:0] o_b2,
  output logic [BCD_W-1:0] o_b1,
  output logic [1:0]       o_phase,
  output logic             o_result_valid,
  output logic             o_op_start
);

  phase_t r_phase;
  phase_t w_phase_nxt;
  logic   r_result_valid;
  logic   r_op_start;
  logic   w_op_start_nxt;
  logic   w_a_clr, w_a_load, w_a_shift;
  logic   w_b_clr, w_b_shift;
  logic   w_is_digit;
  logic   w_do_clr;
  logic   w_timeout;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_tmr;

  // A key in the expiry cycle wins: the timeout only fires on an idle cycle.
  assign w_timeout = !i_key_valid && (r_tmr == TMR_LAST);

  // Saturates at TMR_LAST so the clear keeps asserting until the next key.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmr <= '0;
    end else if (i_key_valid) begin
      r_tmr <= '0;
    end else if (r_tmr != TMR_LAST) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end
`else
  logic [TMR_W-1:0] w_unused_tmr;
  assign w_unused_tmr = TMR_W'(TIMEOUT_CYCLES);
  assign w_timeout    = 1'b0;
`endif

  assign w_is_digit = is_digit(i_key_code);
  assign w_do_clr   = (i_key_valid && (i_key_code == KEY_CLR)) || w_timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase        <= PH_A;
      r_result_valid <= 1'b0;
      r_op_start     <= 1'b0;
    end else begin
      r_phase        <= w_phase_nxt;
      r_result_valid <= (w_phase_nxt == PH_RES);
      r_op_start     <= w_op_start_nxt;
    end
  end

  always_comb begin
    w_phase_nxt    = r_phase;
    w_op_start_nxt = 1'b0;
    w_a_clr        = 1'b0;
    w_a_load       = 1'b0;
    w_a_shift      = 1'b0;
    w_b_clr        = 1'b0;
    w_b_shift      = 1'b0;
    if (w_do_clr) begin
      w_a_clr     = 1'b1;
      w_b_clr     = 1'b1;
      w_phase_nxt = PH_A;
    end else if (i_key_valid) begin
      case (r_phase)
        PH_A: begin
          if (w_is_digit) begin
            w_a_shift = 1'b1;
          end else if (i_key_code == KEY_MINUS) begin
            w_b_clr     = 1'b1;
            w_phase_nxt = PH_B;
          end
        end
        PH_B: begin
          if (w_is_digit) begin
            w_b_shift = 1'b1;
          end else if (i_key_code == KEY_EQ) begin
            w_phase_nxt    = PH_RES;
            w_op_start_nxt = 1'b1;
          end
        end
        PH_RES: begin
          // A digit here starts a new calculation with that digit as A.
          if (w_is_digit) begin
            w_a_load    = 1'b1;
            w_b_clr     = 1'b1;
            w_phase_nxt = PH_A;
          end
        end
        default: w_phase_nxt = PH_A;
      endcase
    end
  end

  bcd_digit_reg u_op_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_a_clr),
    .i_load  (w_a_load),
    .i_shift (w_a_shift),
    .i_digit (i_key_code),
    .o_tens  (o_a2),
    .o_units (o_a1)
  );

  bcd_digit_reg u_op_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_b_clr),
    .i_load  (1'b0),
    .i_shift (w_b_shift),
    .i_digit (i_key_code),
    .o_tens  (o_b2),
    .o_units (o_b1)
  );

  assign o_phase        = r_phase;
  assign o_result_valid = r_result_valid;
  assign o_op_start     = r_op_start;

endmodule
